// File: rtl/bird_sprite_render_if.sv
// Signal bundle between the VGA timing/physics side and the bird sprite
// renderer, including the bird ROM address/data pair.
// master: drives pixel stream, bird position, game events and ROM data.
// slave : the renderer (bird_sprite_render).
interface bird_sprite_render_if;
   logic        frame_start;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        video_on;
   logic [9:0]  bird_x;
   logic [9:0]  bird_y;
   logic [11:0] bg_rgb;
   logic        hit;
   logic        restart;
   logic [4:0]  rom_row;
   logic [4:0]  rom_col;
   logic [11:0] rom_pixel;
   logic [11:0] rgb;
   logic        bird_on;
   logic        video_on_d;

   modport master (
      output frame_start, pix_x, pix_y, video_on, bird_x, bird_y, bg_rgb,
             hit, restart, rom_pixel,
      input  rom_row, rom_col, rgb, bird_on, video_on_d
   );

   modport slave (
      input  frame_start, pix_x, pix_y, video_on, bird_x, bird_y, bg_rgb,
             hit, restart, rom_pixel,
      output rom_row, rom_col, rgb, bird_on, video_on_d
   );
endinterface

// File: rtl/bird_sprite_render.sv
// Bird sprite renderer: latches bird position per frame, addresses the
// 24x24 bird ROM, absorbs its 1-cycle read latency and overlays the bird
// on the background with a fixed 3-clock latency. Also runs the bird life
// FSM (ALIVE / FLASH / DEAD).
// Optional feature macro: BIRD_TRANSPARENCY_EN (pixels equal to KEY_COLOR
// show the background instead of the bird).
module bird_sprite_render #(
   parameter int          SPRITE_W     = 24,
   parameter int          SPRITE_H     = 24,
   parameter int          FLASH_FRAMES = 32,
   parameter logic [11:0] KEY_COLOR    = 12'h000,
   parameter logic [11:0] DEAD_COLOR   = 12'h888
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bird_sprite_render_if.slave   bus
);

   localparam int CW = (FLASH_FRAMES > 8) ? $clog2(FLASH_FRAMES) : 3;

   typedef enum logic [1:0] {ST_ALIVE, ST_FLASH, ST_DEAD} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_flash_cnt;
   logic            r_hit_p;
   logic            r_rst_p;
   logic [9:0]      r_bx;
   logic [9:0]      r_by;

   logic            r_in1, r_von1;
   logic [11:0]     r_bg1;
   logic            r_in2, r_von2;
   logic [11:0]     r_bg2;

   logic [10:0]     w_x_end, w_y_end;
   logic            w_in_box;
   logic [4:0]      w_col, w_row;
   logic            w_hit_e, w_rst_e;
   logic            w_vis, w_opaque;

   // 11-bit bounds so a sprite near 1023 clips instead of wrapping to 0
   assign w_x_end  = {1'b0, r_bx} + 11'(SPRITE_W);
   assign w_y_end  = {1'b0, r_by} + 11'(SPRITE_H);
   assign w_in_box = ({1'b0, bus.pix_x} >= {1'b0, r_bx}) && ({1'b0, bus.pix_x} < w_x_end) &&
                     ({1'b0, bus.pix_y} >= {1'b0, r_by}) && ({1'b0, bus.pix_y} < w_y_end);
   // low 5 bits of the offset only depend on the low 5 bits of each operand
   assign w_col    = bus.pix_x[4:0] - r_bx[4:0];
   assign w_row    = bus.pix_y[4:0] - r_by[4:0];

   // events arriving on the frame_start cycle itself count at that frame_start
   assign w_hit_e  = r_hit_p | bus.hit;
   assign w_rst_e  = r_rst_p | bus.restart;

   assign w_vis    = r_in2 && !(r_state == ST_FLASH && r_flash_cnt[2]);

`ifdef BIRD_TRANSPARENCY_EN
   assign w_opaque = (bus.rom_pixel != KEY_COLOR);
`else
   // key colour only matters with transparency enabled
   logic [11:0] w_unused_key;
   assign w_unused_key = KEY_COLOR;
   assign w_opaque     = 1'b1;
`endif

   // Life FSM, position latch and hit/restart pending flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ALIVE;
         r_flash_cnt <= '0;
         r_hit_p     <= 1'b0;
         r_rst_p     <= 1'b0;
         r_bx        <= '0;
         r_by        <= '0;
      end else if (bus.frame_start) begin
         r_bx    <= bus.bird_x;
         r_by    <= bus.bird_y;
         r_hit_p <= 1'b0;
         r_rst_p <= 1'b0;
         if (w_rst_e) begin
            r_state     <= ST_ALIVE;
            r_flash_cnt <= '0;
         end else begin
            case (r_state)
               ST_ALIVE: if (w_hit_e) begin
                  r_state     <= ST_FLASH;
                  r_flash_cnt <= '0;
               end
               ST_FLASH: if (r_flash_cnt == CW'(FLASH_FRAMES - 1)) r_state <= ST_DEAD;
                         else r_flash_cnt <= r_flash_cnt + CW'(1);
               default:  r_state <= ST_DEAD;
            endcase
         end
      end else begin
         r_hit_p <= r_hit_p | bus.hit;
         r_rst_p <= r_rst_p | bus.restart;
      end
   end

   // Stage 1: ROM address generation and box test
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rom_row <= '0;
         bus.rom_col <= '0;
         r_in1       <= 1'b0;
         r_von1      <= 1'b0;
         r_bg1       <= '0;
      end else begin
         bus.rom_row <= w_in_box ? w_row : '0;
         bus.rom_col <= w_in_box ? w_col : '0;
         r_in1       <= w_in_box;
         r_von1      <= bus.video_on;
         r_bg1       <= bus.bg_rgb;
      end
   end

   // Stage 2: wait out the ROM read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in2  <= 1'b0;
         r_von2 <= 1'b0;
         r_bg2  <= '0;
      end else begin
         r_in2  <= r_in1;
         r_von2 <= r_von1;
         r_bg2  <= r_bg1;
      end
   end

   // Stage 3: bird-over-background mux into the output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rgb        <= '0;
         bus.bird_on    <= 1'b0;
         bus.video_on_d <= 1'b0;
      end else begin
         bus.video_on_d <= r_von2;
         if (!r_von2) begin
            bus.rgb     <= '0;
            bus.bird_on <= 1'b0;
         end else if (w_vis && w_opaque) begin
            bus.rgb     <= (r_state == ST_DEAD) ? DEAD_COLOR : bus.rom_pixel;
            bus.bird_on <= 1'b1;
         end else begin
            bus.rgb     <= r_bg2;
            bus.bird_on <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bird_sprite_render.sv
// Testbench for bird_sprite_render: directed frame sequence with random
// pixels/background/ROM contents, checked against a frame-level model of
// the bird (position per frame, frames-since-hit life counter).
module tb_bird_sprite_render;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bird_sprite_render_if bus();

   bird_sprite_render #(
      .SPRITE_W    (24),
      .SPRITE_H    (24),
      .FLASH_FRAMES(32),
      .KEY_COLOR   (12'h000),
      .DEAD_COLOR  (12'h888)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // synchronous-read bird ROM, indexed {row, col}
   logic [11:0] rom [0:1023];
   always @(posedge clk) bus.rom_pixel <= rom[{bus.rom_row, bus.rom_col}];

   typedef struct {
      logic [11:0] rgb;
      logic        on;
      logic        von;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // model: m_f = -1 alive, 0..31 frames into flashing, 32 dead
   int   m_f, m_bx, m_by;
   bit   m_hp, m_rp;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_f = -1; m_bx = 0; m_by = 0; m_hp = 0; m_rp = 0;
      q.delete();
   endtask

   task automatic tick();
      exp_t e;
      int dx, dy;
      bit inb, hidden, opq;
      logic [4:0] er, ec;
      logic [11:0] rv;
      dx  = int'(bus.pix_x) - m_bx;
      dy  = int'(bus.pix_y) - m_by;
      inb = (dx >= 0) && (dx < 24) && (dy >= 0) && (dy < 24);
      er  = inb ? 5'(dy) : 5'd0;
      ec  = inb ? 5'(dx) : 5'd0;
      rv  = rom[{5'(dy), 5'(dx)}];
      hidden = (m_f >= 0) && (m_f < 32) && (((m_f / 4) % 2) == 1);
`ifdef BIRD_TRANSPARENCY_EN
      opq = (rv != 12'h000);
`else
      opq = 1'b1;
`endif
      if (!bus.video_on)               e = '{12'h000, 1'b0, 1'b0};
      else if (inb && !hidden && opq)  e = '{(m_f >= 32) ? 12'h888 : rv, 1'b1, 1'b1};
      else                             e = '{bus.bg_rgb, 1'b0, 1'b1};
      q.push_back(e);
      if (bus.frame_start) begin
         if (m_rp || bus.restart)                 m_f = -1;
         else if (m_f < 0 && (m_hp || bus.hit))   m_f = 0;
         else if (m_f >= 0 && m_f < 32)           m_f++;
         m_hp = 0; m_rp = 0;
         m_bx = int'(bus.bird_x); m_by = int'(bus.bird_y);
      end else begin
         m_hp = m_hp | bus.hit;
         m_rp = m_rp | bus.restart;
      end
      @(posedge clk); #1;
      chk("rom_row", {7'd0, bus.rom_row}, {7'd0, er});
      chk("rom_col", {7'd0, bus.rom_col}, {7'd0, ec});
      if (q.size() == 3) begin
         e = q.pop_front();
         chk("rgb",        bus.rgb,                e.rgb);
         chk("bird_on",    {11'd0, bus.bird_on},    {11'd0, e.on});
         chk("video_on_d", {11'd0, bus.video_on_d}, {11'd0, e.von});
      end else begin
         chk("fill_rgb",  bus.rgb,                12'h000);
         chk("fill_on",   {11'd0, bus.bird_on},    12'h000);
         chk("fill_von",  {11'd0, bus.video_on_d}, 12'h000);
      end
      bus.frame_start = 1'b0;
      bus.hit         = 1'b0;
      bus.restart     = 1'b0;
   endtask

   task automatic pix(input int x, input int y, input bit von, input logic [11:0] bg);
      bus.pix_x    = 10'(x);
      bus.pix_y    = 10'(y);
      bus.video_on = von;
      bus.bg_rgb   = bg;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 12'($urandom));
   endtask

   task automatic frame(input int nx, input int ny, input bit h, input bit r);
      idle(3);
      bus.frame_start = 1'b1;
      bus.bird_x      = 10'(nx);
      bus.bird_y      = 10'(ny);
      bus.hit         = h;
      bus.restart     = r;
      idle(1);
      // position inputs wander mid-frame; only the latched copy may be used
      bus.bird_x = 10'($urandom);
      bus.bird_y = 10'($urandom);
      idle(3);
   endtask

   task automatic scan(input int rows);
      int y;
      for (int r = 0; r < rows; r++) begin
         y = m_by - 1 + int'($urandom_range(0, 25));
         for (int x = m_bx - 2; x <= m_bx + 25; x++) begin
            if ($urandom_range(0, 15) == 0) bus.bird_y = 10'($urandom);
            pix(x, y, $urandom_range(0, 7) != 0, 12'($urandom));
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_rgb",     bus.rgb,                12'h000);
      chk("rst_bird_on", {11'd0, bus.bird_on},    12'h000);
      chk("rst_von_d",   {11'd0, bus.video_on_d}, 12'h000);
      chk("rst_rom_row", {7'd0, bus.rom_row},     12'h000);
      chk("rst_rom_col", {7'd0, bus.rom_col},     12'h000);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 12'($urandom_range(1, 4095));
      for (int c = 0; c < 32; c++) rom[c] = 12'hFF0;
      rom[{5'd2, 5'd5}]   = 12'h000;
      rom[{5'd10, 5'd20}] = 12'h000;
      rom[{5'd23, 5'd23}] = 12'h000;
      bus.frame_start = 1'b0; bus.hit = 1'b0; bus.restart = 1'b0;
      bus.pix_x = '0; bus.pix_y = '0; bus.video_on = 1'b0; bus.bg_rgb = '0;
      bus.bird_x = '0; bus.bird_y = '0;
      #2;
      do_reset();

      // basic row scan at (100,200) over a blue background
      frame(100, 200, 1'b0, 1'b0);
      for (int x = 99; x <= 124; x++) pix(x, 200, 1'b1, 12'h00F);
      for (int x = 99; x <= 124; x++) pix(x, 202, 1'b1, 12'h00F);
      for (int x = 99; x <= 124; x++) pix(x, 210, 1'b1, 12'h0F0);

      // new position takes effect only from the next frame
      frame(100, 210, 1'b0, 1'b0);
      scan(4);

      // reset in the middle of a scan line drops the pipeline
      for (int x = 100; x < 110; x++) pix(x, 212, 1'b1, 12'h123);
      do_reset();
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 28; x++) pix(x, y, 1'b1, 12'($urandom));

      // hit and restart together on frame_start: stays alive
      frame(300, 100, 1'b1, 1'b1);
      scan(3);
      frame(300, 100, 1'b0, 1'b0);
      scan(2);

      // sprite near bottom-right corner clips without wrapping
      frame(1010, 1015, 1'b0, 1'b0);
      scan(3);

      // hit mid-frame, then flash (with an ignored second hit) and death
      bus.hit = 1'b1;
      pix(1012, 1016, 1'b1, 12'h0AA);
      for (int f = 0; f < 36; f++) begin
         frame(200 + f, 150, 1'b0, 1'b0);
         if (f == 10) begin
            bus.hit = 1'b1;
            pix(m_bx, m_by, 1'b1, 12'h555);
         end
         scan(2);
      end

      // restart mid-frame revives the bird at the next frame
      bus.restart = 1'b1;
      pix(0, 0, 1'b0, 12'h000);
      frame(400, 300, 1'b0, 1'b0);
      scan(3);
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
